cdc_handshake_tx: RTL
=====================

Name: cdc_handshake_tx

Overview:
Source-domain transmitter for a 4-phase req/ack multi-bit clock-domain-crossing transfer. It accepts words from local logic through a valid/ready interface and buffers one word. It drives a held-stable data bus plus a level request to the destination domain, and synchronizes the returning acknowledge internally. The destination side samples tx_req through a multi-flop synchronizer and captures tx_data once the request is seen high.

Parameters:
DATA_WIDTH, 8, width of transferred word
SYNC_STAGES, 2, flops in rx_ack synchronizer chain; legal range 2..4

Ports:
CLK  in  1  source-domain clock
RST  in  1  asynchronous active-low reset
src_data  in  DATA_WIDTH  word from local logic
src_valid  in  1  src_data valid
src_ready  out  1  holding buffer empty; transfer occurs when src_valid && src_ready
tx_data  out  DATA_WIDTH  registered word to destination; stable whenever tx_req=1 or sync ack=1
tx_req  out  1  registered level request to destination domain
rx_ack  in  1  level acknowledge from destination; asynchronous to CLK
done_pulse  out  1  one-cycle pulse when a handshake fully completes
busy  out  1  high when a word is held or a handshake is in progress

Behaviour:
- Interface: reset RST, asynchronous, active-low; clock CLK.
- Reset values: src_ready=1; tx_data=0; tx_req=0; done_pulse=0; busy=0. Internally: ack sync chain all 0, hold_valid=0, FSM=IDLE.
- rx_ack passes through SYNC_STAGES flops to produce ack_s. Only ack_s is used internally.
- Holding buffer (1 entry):
  - src_ready = !hold_valid (registered, no combinational path from FSM).
  - On accept, hold_data<=src_data and hold_valid<=1.
  - hold_valid clears on the edge where the FSM loads tx_data.
  - Accept and load never coincide on one entry.
- FSM states IDLE, REQ, ACK_WAIT_LO:
  - IDLE: if hold_valid && !ack_s, then tx_data<=hold_data, tx_req<=1, hold_valid<=0, go REQ. Otherwise stay.
  - If ack_s=1 in IDLE (stale or illegal ack), stay IDLE, do not load, and keep tx_data unchanged.
  - REQ: tx_req held 1. When ack_s=1, tx_req<=0 and go ACK_WAIT_LO.
  - ACK_WAIT_LO: when ack_s=0, done_pulse<=1 for exactly one cycle and go IDLE.
- tx_data changes only on an IDLE load edge. It is never modified while tx_req=1 or ack_s=1.
- Latency:
  - Word accepted at edge E0 gives hold_valid=1 after E0.
  - tx_req rises at E1 if the FSM is IDLE and ack_s=0.
- Overlap: while a handshake is in flight, the buffer may accept the next word. It is loaded on the first IDLE cycle with ack_s=0, which can be the cycle after done_pulse.
- Minimum cycles per word = 2*SYNC_STAGES + destination round trip + 2.
- busy = hold_valid || (FSM != IDLE).
- Boundary conditions:
  - src_valid held with buffer full: no accept; src_data is ignored.
  - rx_ack glitching is tolerated only via the synchronizer. A single-cycle ack_s pulse in REQ still advances the FSM.
  - Reset mid-operation: all state is cleared immediately (async). Any held or in-flight word is discarded. The destination shares RST distribution and must also reset.
- No timeout. The FSM waits indefinitely for ack_s.

Test Plan:
- Single transfer, DATA_WIDTH=8, SYNC_STAGES=2. Destination model: ack follows sync'd req after 2 dest cycles. Push 0xA5 → tx_data=0xA5 with tx_req=1 one edge after hold_valid sets. tx_data is stable until done_pulse, and done_pulse is high exactly 1 cycle.
- Back-to-back: src_valid held with 0x11, 0x22, 0x33 → src_ready drops after each accept. The destination receives 0x11, 0x22, 0x33 in order, with exactly 3 done_pulses and no data change during any tx_req=1 window.
- Backpressure: buffer full during REQ, src_valid=1 with 0x77 → src_ready=0, no accept. 0x77 is taken in the cycle after hold_valid clears.
- Stale ack: force rx_ack=1 while IDLE with a word held → tx_req stays 0 and tx_data unchanged. Release rx_ack → load occurs SYNC_STAGES+1 edges later.
- Reset mid-handshake: assert RST while in REQ → tx_req, tx_data, busy and done_pulse become 0 immediately and src_ready=1. After release, a new word 0x3C transfers normally.
- Clock ratios: destination at 3x and 1/3x the CLK frequency, 100 random words → all received in order, no drops or duplicates, and the done_pulse count equals 100.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// Source-domain side of a 4-phase req/ack multi-bit CDC transfer.
// One-word holding buffer feeds a held-stable data bus and a level request.
module cdc_handshake_tx #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_req,
    input  logic                  rx_ack,
    output logic                  done_pulse,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK_WAIT_LO
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;

    logic                    hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]   hold_data_q, hold_data_d;
    logic                    src_ready_q, src_ready_d;

    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_req_q, tx_req_d;
    logic                    done_q, done_d;

    logic                    accept;
    logic                    load;

    // rx_ack is asynchronous; only the last stage of the chain is ever used.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], rx_ack};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    assign accept = src_valid && src_ready_q;

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_req_d  = tx_req_q;
        done_d    = 1'b0;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A stale ack blocks the load so tx_data never moves under ack_s=1.
                if (hold_valid_q && !ack_s) begin
                    load      = 1'b1;
                    tx_data_d = hold_data_q;
                    tx_req_d  = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                tx_req_d = 1'b1;
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    state_d  = ST_ACK_WAIT_LO;
                end
            end
            ST_ACK_WAIT_LO: begin
                tx_req_d = 1'b0;
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_req_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // Load needs a full buffer and accept needs an empty one, so they are exclusive.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (load) begin
            hold_valid_d = 1'b0;
        end
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = src_data;
        end
        src_ready_d = !hold_valid_d;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            src_ready_q  <= 1'b1;
            tx_data_q    <= '0;
            tx_req_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            src_ready_q  <= src_ready_d;
            tx_data_q    <= tx_data_d;
            tx_req_q     <= tx_req_d;
            done_q       <= done_d;
        end
    end

    assign src_ready  = src_ready_q;
    assign tx_data    = tx_data_q;
    assign tx_req     = tx_req_q;
    assign done_pulse = done_q;
    assign busy       = hold_valid_q || (state_q != ST_IDLE);

endmodule
